data_mem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters.
- Port 0 is the pipeline MEM stage and has priority. Port 1 is the secondary master (loader/debug).
- Drives the memory's address, write-data, write-enable and read-enable inputs. Returns read data to the winning port through a registered response, and stalls the loser.
- Includes a starvation counter so port 1 is guaranteed access under continuous port 0 traffic.

---
 rtl/data_mem_arbiter.sv | 88 ++++++++
 tb/tb_data_mem_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the single-port data memory: port 0 (MEM stage) has
// priority, port 1 is forced through after MAX_WAIT consecutive denials.
module data_mem_arbiter #(
  parameter int Bits     = 64,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            p0_req,
  input  logic            p0_we,
  input  logic [Bits-1:0] p0_addr,
  input  logic [Bits-1:0] p0_wdata,
  output logic            p0_gnt,
  output logic            p0_stall,
  output logic            p0_rvalid,
  output logic [Bits-1:0] p0_rdata,
  input  logic            p1_req,
  input  logic            p1_we,
  input  logic [Bits-1:0] p1_addr,
  input  logic [Bits-1:0] p1_wdata,
  output logic            p1_gnt,
  output logic            p1_rvalid,
  output logic [Bits-1:0] p1_rdata,
  output logic [Bits-1:0] mem_access_addr,
  output logic [Bits-1:0] mem_write_data,
  output logic            mem_write_en,
  output logic            mem_read,
  input  logic [Bits-1:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, P0, P1} owner_t;

  owner_t     owner, owner_nxt;
  logic [3:0] wait_cnt;
  logic       force1;
  logic       rd_q;

  always_comb begin
    force1          = p1_req && (wait_cnt == 4'(MAX_WAIT));
    // No grants while reset is high, so nothing reaches the memory.
    p1_gnt          = !reset && p1_req && (!p0_req || force1);
    p0_gnt          = !reset && p0_req && !p1_gnt;
    p0_stall        = !reset && p0_req && !p0_gnt;
    mem_access_addr = '0;
    mem_write_data  = '0;
    mem_write_en    = 1'b0;
    mem_read        = 1'b0;
    owner_nxt       = IDLE;
    if (p0_gnt) begin
      mem_access_addr = p0_addr;
      mem_write_data  = p0_wdata;
      mem_write_en    = p0_we;
      mem_read        = !p0_we;
      owner_nxt       = P0;
    end else if (p1_gnt) begin
      mem_access_addr = p1_addr;
      mem_write_data  = p1_wdata;
      mem_write_en    = p1_we;
      mem_read        = !p1_we;
      owner_nxt       = P1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner    <= IDLE;
      wait_cnt <= '0;
      rd_q     <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      owner <= owner_nxt;
      rd_q  <= mem_read;
      if (p1_gnt || !p1_req)
        wait_cnt <= '0;
      else if (wait_cnt < 4'(MAX_WAIT))
        wait_cnt <= wait_cnt + 4'd1;
      // rdata holds until that port's next read
      if (p0_gnt && !p0_we) p0_rdata <= mem_read_data;
      if (p1_gnt && !p1_we) p1_rdata <= mem_read_data;
    end
  end

  // A read issued last cycle returns to whichever port owned the memory then.
  assign p0_rvalid = rd_q && (owner == P0);
  assign p1_rvalid = rd_q && (owner == P1);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: a reference model predicts grants and
// memory contents; read responses are queued and checked by a separate monitor.
module tb_data_mem_arbiter;
  localparam int BITS = 64;
  localparam int MW   = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [BITS-1:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
  logic            p0_gnt, p0_stall, p0_rvalid, p1_gnt, p1_rvalid;
  logic [BITS-1:0] p0_rdata, p1_rdata;
  logic [BITS-1:0] mem_access_addr, mem_write_data, mem_read_data;
  logic            mem_write_en, mem_read;

  data_mem_arbiter #(.Bits(BITS), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_stall(p0_stall), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Physical memory: 256 words, upper address bits ignored.
  logic [BITS-1:0] mem [256];
  assign mem_read_data = mem[mem_access_addr[7:0]];
  always @(posedge clk) if (mem_write_en) mem[mem_access_addr[7:0]] <= mem_write_data;

  // Reference model state
  logic [BITS-1:0] ref_mem [256];
  logic [BITS-1:0] q0[$], q1[$];
  logic [BITS-1:0] hold0 = '0, hold1 = '0;
  int              denied = 0;   // consecutive cycles port 1 has been passed over
  logic            e0, e1;
  int              total = 0, bad = 0;
  logic            rst_s;

  task automatic chk(input string nm, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst,
                      input logic r0, input logic w0, input logic [BITS-1:0] a0, input logic [BITS-1:0] d0,
                      input logic r1, input logic w1, input logic [BITS-1:0] a1, input logic [BITS-1:0] d1);
    logic [BITS-1:0] ea, ed;
    @(negedge clk);
    reset = rst; p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    #1;
    if (rst) begin
      e0 = 0; e1 = 0;
    end else begin
      e1 = r1 && (!r0 || denied >= MW);
      e0 = r0 && !e1;
    end
    ea = e0 ? a0 : (e1 ? a1 : '0);
    ed = e0 ? d0 : (e1 ? d1 : '0);
    chk("p0_gnt", 64'(p0_gnt), 64'(e0));
    chk("p1_gnt", 64'(p1_gnt), 64'(e1));
    chk("p0_stall", 64'(p0_stall), 64'(!rst && r0 && !e0));
    chk("mem_addr", mem_access_addr, ea);
    chk("mem_wdata", mem_write_data, ed);
    chk("mem_we", 64'(mem_write_en), 64'((e0 && w0) || (e1 && w1)));
    chk("mem_read", 64'(mem_read), 64'((e0 && !w0) || (e1 && !w1)));
    if (e0) begin
      if (w0) ref_mem[a0[7:0]] = d0; else q0.push_back(ref_mem[a0[7:0]]);
    end
    if (e1) begin
      if (w1) ref_mem[a1[7:0]] = d1; else q1.push_back(ref_mem[a1[7:0]]);
    end
    if (rst || !r1 || e1) denied = 0; else denied++;
  endtask

  // Monitor: responses appear in the cycle after their read grant.
  always @(posedge clk) begin
    rst_s = reset;
    #2;
    if (rst_s) begin
      hold0 = '0; hold1 = '0;
      q0.delete(); q1.delete();
      chk("p0_rvalid_rst", 64'(p0_rvalid), 64'(0));
      chk("p1_rvalid_rst", 64'(p1_rvalid), 64'(0));
    end else begin
      if (q0.size() > 0) begin
        hold0 = q0.pop_front();
        chk("p0_rvalid", 64'(p0_rvalid), 64'(1));
      end else chk("p0_rvalid_idle", 64'(p0_rvalid), 64'(0));
      if (q1.size() > 0) begin
        hold1 = q1.pop_front();
        chk("p1_rvalid", 64'(p1_rvalid), 64'(1));
      end else chk("p1_rvalid_idle", 64'(p1_rvalid), 64'(0));
    end
    chk("p0_rdata", p0_rdata, hold0);
    chk("p1_rdata", p1_rdata, hold1);
  end

  logic [BITS-1:0] Z = '0;

  initial begin
    logic pr0, pw0, pr1, pw1;
    logic [BITS-1:0] pa0, pd0, pa1, pd1;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = {32'(i) * 32'h01010101, 32'hC0DE_0000 + 32'(i)};
      ref_mem[i] = {32'(i) * 32'h01010101, 32'hC0DE_0000 + 32'(i)};
    end
    mem[16] = 64'hAA; ref_mem[16] = 64'hAA;

    step(1, 0, 0, Z, Z, 0, 0, Z, Z);
    step(1, 1, 0, 64'h10, Z, 1, 1, 64'h20, 64'h9);   // requests ignored in reset
    // p0 read of 0x10
    step(0, 1, 0, 64'h10, Z, 0, 0, Z, Z);
    // p1 write then read back
    step(0, 0, 0, Z, Z, 1, 1, 64'h20, 64'h1234);
    step(0, 0, 0, Z, Z, 1, 0, 64'h20, Z);
    step(0, 0, 0, Z, Z, 0, 0, Z, Z);
    // continuous contention: p0 x4, p1 x1 repeating
    for (int i = 0; i < 15; i++)
      step(0, 1, 0, 64'(i), Z, 1, 0, 64'(i + 32), Z);
    step(0, 0, 0, Z, Z, 0, 0, Z, Z);
    // p0 contends only for two cycles
    step(0, 1, 0, 64'h1, Z, 1, 0, 64'h5, Z);
    step(0, 1, 0, 64'h2, Z, 1, 0, 64'h5, Z);
    step(0, 0, 0, Z, Z, 1, 0, 64'h5, Z);
    // read grant then reset, then immediate grant after reset
    step(0, 1, 0, 64'h7, Z, 0, 0, Z, Z);
    step(1, 1, 0, 64'h8, Z, 1, 0, 64'h9, Z);
    step(0, 1, 0, 64'h8, Z, 0, 0, Z, Z);
    // write-then-read across ports; upper address bits pass through
    step(0, 1, 1, 64'h3, 64'h55, 0, 0, Z, Z);
    step(0, 0, 0, Z, Z, 1, 0, 64'hFF00_0000_0000_0003, Z);
    // back-to-back reads
    step(0, 1, 0, 64'h4, Z, 0, 0, Z, Z);
    step(0, 1, 0, 64'h5, Z, 0, 0, Z, Z);
    step(0, 1, 0, 64'h6, Z, 0, 0, Z, Z);

    // randomized traffic with held requests and occasional cancels/resets
    pr0 = 0; pr1 = 0; pw0 = 0; pw1 = 0; pa0 = Z; pa1 = Z; pd0 = Z; pd1 = Z;
    for (int c = 0; c < 600; c++) begin
      logic rs;
      if (!pr0 && $urandom_range(0, 2) != 0) begin
        pr0 = 1; pw0 = $urandom_range(0, 1) == 1;
        pa0 = {$urandom(), $urandom()}; if ($urandom_range(0, 7) != 0) pa0 = pa0 % 16;
        pd0 = {$urandom(), $urandom()};
      end
      if (!pr1 && $urandom_range(0, 1) != 0) begin
        pr1 = 1; pw1 = $urandom_range(0, 1) == 1;
        pa1 = {$urandom(), $urandom()}; if ($urandom_range(0, 7) != 0) pa1 = pa1 % 16;
        pd1 = {$urandom(), $urandom()};
      end
      if (pr0 && $urandom_range(0, 19) == 0) pr0 = 0;
      if (pr1 && $urandom_range(0, 19) == 0) pr1 = 0;
      rs = $urandom_range(0, 99) == 0;
      step(rs, pr0, pw0, pa0, pd0, pr1, pw1, pa1, pd1);
      if (e0) pr0 = 0;
      if (e1) pr1 = 0;
    end
    step(0, 0, 0, Z, Z, 0, 0, Z, Z);
    step(0, 0, 0, Z, Z, 0, 0, Z, Z);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
